// File: rtl/softmax_pkg.sv
// Shared types and fixed-point helpers for the sequential softmax.
// The Taylor exp approximation is a pure function so it can be reused or checked standalone.
package softmax_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAX,
        EXP,
        DIV,
        ADJ,
        OUT
    } state_t;

    function automatic int fx_one(input int unsigned frac);
        return 1 << frac;
    endfunction

    function automatic int fx_min_x(input int unsigned frac);
        return -(2 << frac);
    endfunction

    // Six-term series about 0; x is expected <= 0 and is clipped at -2.0.
    function automatic int exp_taylor(input int x, input int unsigned frac);
        int xc;
        int term;
        int acc;
        xc   = (x < fx_min_x(frac)) ? fx_min_x(frac) : x;
        term = fx_one(frac);
        acc  = term;
        for (int unsigned k = 1; k <= 5; k++) begin
            term = (term * xc) >>> frac;
            term = term / int'(k);
            acc  = acc + term;
        end
        return (acc < 0) ? 0 : acc;
    endfunction

endpackage

// File: rtl/softmax_serial_div.sv
// Restoring radix-2 divider: one quotient bit per cycle, MSB first, Q_W cycles per divide.
// The first step uses i_num directly so back-to-back divides have no idle cycle.
module softmax_serial_div #(
    parameter int unsigned NUM_W = 28,
    parameter int unsigned DEN_W = 19,
    parameter int unsigned Q_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic             o_busy,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quot
);

    localparam int unsigned RW = (NUM_W > DEN_W + Q_W) ? NUM_W : DEN_W + Q_W;
    localparam int unsigned CW = (Q_W > 1) ? $clog2(Q_W) : 1;

    logic          r_active;
    logic [CW-1:0] r_bit;
    logic [RW-1:0] r_rem;
    logic [Q_W-1:0] r_quot;

    logic [RW-1:0]  w_rem_cur;
    logic [RW-1:0]  w_trial;
    logic [RW-1:0]  w_rem_nxt;
    logic [Q_W-1:0] w_q_cur;
    logic [Q_W-1:0] w_q_nxt;
    logic [CW-1:0]  w_bit;
    logic           w_ge;
    logic           w_step;

    always_comb begin
        w_rem_cur = r_active ? r_rem  : RW'(i_num);
        w_q_cur   = r_active ? r_quot : '0;
        w_bit     = r_active ? r_bit  : CW'(Q_W - 1);
        w_trial   = RW'(i_den) << w_bit;
        w_ge      = (w_rem_cur >= w_trial);
        w_rem_nxt = w_ge ? (w_rem_cur - w_trial) : w_rem_cur;
        w_q_nxt   = w_q_cur | (w_ge ? (Q_W'(1) << w_bit) : '0);
        w_step    = r_active || i_start;
        o_done    = w_step && (w_bit == '0);
        o_quot    = (i_den == '0) ? '0 : w_q_nxt;
        o_busy    = r_active;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_bit    <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
        end else if (w_step) begin
            if (w_bit == '0) begin
                r_active <= 1'b0;
            end else begin
                r_active <= 1'b1;
                r_bit    <= w_bit - 1'b1;
                r_rem    <= w_rem_nxt;
                r_quot   <= w_q_nxt;
            end
        end
    end

endmodule

// File: rtl/softmax_seq.sv
// Sequential handshaked fixed-point softmax: max scan, Taylor exp, serial divide, sum fix-up.
// Define SOFTMAX_SUM_CORRECT_EN to fold the rounding residue into the argmax element.
module softmax_seq
    import softmax_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE*WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam int unsigned SUM_W = WIDTH + $clog2(SIZE) + 1;
    localparam int unsigned Q_W   = FRAC + 1;
    localparam int unsigned NUM_W = SUM_W + FRAC + 1;
    localparam int unsigned IW    = $clog2(SIZE);

    state_t r_state;
    state_t w_next;

    logic signed [WIDTH-1:0] r_x [SIZE];
    logic signed [WIDTH-1:0] r_max;
    logic [WIDTH-1:0]        r_exp [SIZE];
    logic [Q_W-1:0]          r_q [SIZE];
    logic [SUM_W-1:0]        r_sum;
    logic [IW-1:0]           r_idx;
    logic [SIZE*WIDTH-1:0]   r_out;

    logic                  w_last;
    int                    w_exp;
    logic                  w_div_start;
    logic                  w_div_busy;
    logic                  w_div_done;
    logic [Q_W-1:0]        w_div_q;
    logic [NUM_W-1:0]      w_div_num;
    logic [SIZE*WIDTH-1:0] w_adj;

    assign w_last      = (r_idx == IW'(SIZE - 1));
    assign w_exp       = exp_taylor(int'(r_x[r_idx]) - int'(r_max), FRAC);
    assign w_div_start = (r_state == DIV) && !w_div_busy;
    assign w_div_num   = (NUM_W'(r_exp[r_idx]) << FRAC) + NUM_W'(r_sum >> 1);

    softmax_serial_div #(
        .NUM_W (NUM_W),
        .DEN_W (SUM_W),
        .Q_W   (Q_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_div_start),
        .i_num   (w_div_num),
        .i_den   (r_sum),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_quot  (w_div_q)
    );

`ifdef SOFTMAX_SUM_CORRECT_EN
    localparam int unsigned QS_W = Q_W + IW + 1;
    logic [QS_W-1:0] w_qsum;
    logic [IW-1:0]   w_amax;
    logic [Q_W-1:0]  w_best;
    int              w_fix;
`endif

    always_comb begin
        w_adj = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            w_adj[i*WIDTH +: WIDTH] = WIDTH'(r_q[i]);
        end
`ifdef SOFTMAX_SUM_CORRECT_EN
        w_qsum = '0;
        w_amax = '0;
        w_best = r_q[0];
        // Strict compare keeps the lowest index on ties.
        for (int unsigned i = 0; i < SIZE; i++) begin
            w_qsum = w_qsum + QS_W'(r_q[i]);
            if (r_q[i] > w_best) begin
                w_best = r_q[i];
                w_amax = IW'(i);
            end
        end
        w_fix = int'(w_best) + fx_one(FRAC) - int'(w_qsum);
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (IW'(i) == w_amax) begin
                w_adj[i*WIDTH +: WIDTH] = WIDTH'(w_fix);
            end
        end
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid)                w_next = MAX;
            MAX:  if (w_last)                  w_next = EXP;
            EXP:  if (w_last)                  w_next = DIV;
            DIV:  if (w_div_done && w_last)    w_next = ADJ;
            ADJ:                               w_next = OUT;
            OUT:  if (out_ready)               w_next = IDLE;
            default:                           w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                r_x[i]   <= '0;
                r_exp[i] <= '0;
                r_q[i]   <= '0;
            end
            r_max <= '0;
            r_sum <= '0;
            r_idx <= '0;
            r_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < SIZE; i++) begin
                            r_x[i] <= in_data[i*WIDTH +: WIDTH];
                        end
                        r_idx <= '0;
                    end
                end
                MAX: begin
                    if ((r_idx == '0) || (r_x[r_idx] > r_max)) begin
                        r_max <= r_x[r_idx];
                    end
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                EXP: begin
                    r_exp[r_idx] <= WIDTH'(w_exp);
                    r_sum        <= ((r_idx == '0) ? '0 : r_sum) + SUM_W'(w_exp);
                    r_idx        <= w_last ? '0 : r_idx + 1'b1;
                end
                DIV: begin
                    if (w_div_done) begin
                        r_q[r_idx] <= w_div_q;
                        r_idx      <= w_last ? '0 : r_idx + 1'b1;
                    end
                end
                ADJ: r_out <= w_adj;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == OUT);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_out;

endmodule

// File: tb/tb_softmax_seq.sv
// Directed-vector bench for softmax_seq with hand-computed results (both SOFTMAX_SUM_CORRECT_EN builds).
module tb_softmax_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int n_vec;
    int n_err;

`ifdef SOFTMAX_SUM_CORRECT_EN
    localparam int C = 1;
`else
    localparam int C = 0;
`endif

    softmax_seq #(
        .WIDTH (16),
        .FRAC  (8),
        .SIZE  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Drives one vector, measures accept-to-out_valid latency and checks the result.
    task automatic run(input string tag, input logic [63:0] v, input logic [63:0] exp_out,
                       input bit hold);
        int n;
        logic [63:0] other;
        @(negedge clk);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        in_data  = v;
        in_valid = 1'b1;
        out_ready = hold ? 1'b0 : 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd45);
        check({tag, "_data"}, out_data, exp_out);
        if (hold) begin
            other = pk(100, -100, 7, 3);
            for (int unsigned i = 0; i < 10; i++) begin
                in_data  = other;
                in_valid = 1'b1;
                @(posedge clk);
                #1;
                check({tag, "_hold_v"}, 64'(out_valid), 64'd1);
                check({tag, "_hold_d"}, out_data, exp_out);
                check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_post_v"}, 64'(out_valid), 64'd0);
        check({tag, "_post_rdy"}, 64'(in_ready), 64'd1);
        if (hold) begin
            repeat (3) @(posedge clk);
            #1;
            check({tag, "_nocap"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        run("zeros",  pk(0, 0, 0, 0),             pk(64, 64, 64, 64), 1'b0);
        run("one_hi", pk(256, 0, 0, 0),           pk(122 - C, 45, 45, 45), 1'b0);
        run("clip",   pk(0, -2048, -2048, -2048), pk(213 + C, 14, 14, 14), 1'b0);
        run("tie",    pk(128, 128, 0, 0),         pk(80, 80, 48, 48), 1'b0);
        run("neg",    pk(-256, -512, -512, -512), pk(122 - C, 45, 45, 45), 1'b0);
        run("hold",   pk(0, 256, 0, 0),           pk(45, 122 - C, 45, 45), 1'b1);

        // Abort mid-divide, then confirm a clean restart.
        @(negedge clk);
        in_data  = pk(0, 0, 0, 0);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(in_ready), 64'd1);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_data", out_data, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        run("after_rst", pk(256, 0, 0, 0), pk(122 - C, 45, 45, 45), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
